alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one combinational ALU between NUM_REQ requesters (e.g. execute stage,
//   branch/address unit). Arbitrates valid/ready requests, drives the ALU
//   operands and control, and registers result + branch condition into a
//   one-entry response slot tagged with the winner's index. Sits between the
//   issuing units and the single alu instance.
// PARAMETERS
//   NUM_REQ   2   number of requesters (2..8)
//   ID_W      $clog2(NUM_REQ)   width of requester index (localparam)
// PORTS
//   clk_i              in   1            clock
//   rst_i              in   1            synchronous reset, active high
//   req_valid_i        in   NUM_REQ      request valid per requester
//   req_ready_o        out  NUM_REQ      request accepted this cycle (one-hot or 0)
//   req_a_i            in   NUM_REQ*32   operand a per requester
//   req_b_i            in   NUM_REQ*32   operand b per requester
//   req_control_i      in   NUM_REQ*4    alu control (params_pkg *_ALU_CONTROL)
//   alu_a_o            out  32           to alu a_i
//   alu_b_o            out  32           to alu b_i
//   alu_control_o      out  4            to alu control_i
//   alu_result_i       in   32           from alu result_o
//   alu_branch_cond_i  in   1            from alu branch_cond_o
//   rsp_valid_o        out  1            response slot full
//   rsp_ready_i        in   1            consumer takes response
//   rsp_id_o           out  ID_W         index of requester that issued the op
//   rsp_result_o       out  32           registered alu result
//   rsp_branch_cond_o  out  1            registered branch condition
// BEHAVIOUR
// - Reset (sync, rst_i high): rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0,
//   rsp_branch_cond_o=0, rr pointer=0. req_ready_o=0 while rst_i high.
// - slot_free = !rsp_valid_o | rsp_ready_i. No grant when !slot_free.
// - Grant (combinational): among req_valid_i, first index at or after rr
//   pointer, wrapping mod NUM_REQ. req_ready_o[g]=1 only for winner when
//   slot_free. At most one ready bit high per cycle.
// - Accept = valid & ready. On accept in cycle t: ALU driven from winner in t;
//   slot loads result, branch_cond, id=g at edge; rsp_valid_o=1 in t+1.
//   Latency 1 cycle; throughput 1 op/cycle when rsp_ready_i held high.
// - rr pointer <= (g+1) mod NUM_REQ on accept; unchanged otherwise.
// - No accept: alu_a_o=0, alu_b_o=0, alu_control_o=0; slot keeps contents.
// - Response drain without new accept: rsp_valid_o -> 0; data regs hold value.
// - Drain and accept in same cycle: slot overwritten, rsp_valid_o stays 1.
// - Requesters hold a/b/control stable while valid & !ready; arbiter does not
//   latch requests. Deasserting valid before accept is legal (request dropped).
// - Backpressure: rsp_valid_o & !rsp_ready_i -> all req_ready_o=0, slot
//   stable, pointer frozen.
// - Reset mid-operation: pending slot discarded, no response emitted.
// - Responses leave in acceptance order; no reordering.
// CONFIGURATION
//   ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest valid index always
//     wins; rr pointer removed (starvation of high indices is allowed).
//   Not defined: round-robin as above (default).
// TESTING
//   1. rst_i high 2 cycles, all req_valid_i=1 -> req_ready_o=0, rsp_valid_o=0;
//      after release first grant to req0.
//   2. req0 a=5 b=3 ADD, rsp_ready_i=1 -> ready0=1 same cycle; next cycle
//      rsp_valid_o=1, rsp_id_o=0, rsp_result_o=8.
//   3. req0/req1 valid every cycle, rsp_ready_i=1 -> grants 0,1,0,1; ids in
//      rsp stream alternate, one response per cycle.
//   4. Slot full, rsp_ready_i=0 for 3 cycles -> req_ready_o=0, rsp_* stable;
//      raise rsp_ready_i -> drain and new accept same cycle, rsp_valid_o stays 1.
//   5. req1 a=0xFFFFFFFF b=1 LT_ALU_CONTROL -> rsp_result_o=1,
//      rsp_branch_cond_o=1, rsp_id_o=1; LTU same operands -> 0 and 0.
//   6. ALU_ARB_FIXED_PRIO_EN, req0/req1 valid 4 cycles -> req0 granted every
//      cycle, req1 never; default build -> req1 granted in cycles 2 and 4.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters and holds a one-entry tagged response slot.
// Defining ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins); otherwise round-robin.

module alu_arbiter_lane (
   input  logic        grant,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  control,
   output logic [31:0] a_masked,
   output logic [31:0] b_masked,
   output logic [3:0]  control_masked
);
   // Non-granted lanes contribute zero, so the AND-OR mux idles at 0.
   assign a_masked       = grant ? a       : '0;
   assign b_masked       = grant ? b       : '0;
   assign control_masked = grant ? control : '0;
endmodule

module alu_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ-1:0][31:0]      req_a_i,
   input  logic [NUM_REQ-1:0][31:0]      req_b_i,
   input  logic [NUM_REQ-1:0][3:0]       req_control_i,
   output logic [31:0]                   alu_a_o,
   output logic [31:0]                   alu_b_o,
   output logic [3:0]                    alu_control_o,
   input  logic [31:0]                   alu_result_i,
   input  logic                          alu_branch_cond_i,
   output logic                          rsp_valid_o,
   input  logic                          rsp_ready_i,
   output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
   output logic [31:0]                   rsp_result_o,
   output logic                          rsp_branch_cond_o
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic                     slot_free;
   logic                     grant_vld;
   logic [ID_W-1:0]          grant_id;
   logic                     accept;
   logic [NUM_REQ-1:0]       grant_oh;
   logic [NUM_REQ-1:0][31:0] a_masked;
   logic [NUM_REQ-1:0][31:0] b_masked;
   logic [NUM_REQ-1:0][3:0]  control_masked;

   assign slot_free = !rsp_valid_o || rsp_ready_i;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Descending scan so the lowest valid index is the last (winning) assignment.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(i);
         end
      end
   end
`else
   logic [ID_W-1:0] rr_ptr;

   // Scan offsets from the far end so the smallest offset from rr_ptr wins.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req_valid_i[idx]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end
`endif

   assign accept = grant_vld && slot_free && !rst_i;

   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_oh[i] = accept && (grant_id == ID_W'(i));
      end
   end

   assign req_ready_o = grant_oh;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      alu_arbiter_lane u_lane (
         .grant          (grant_oh[g]),
         .a              (req_a_i[g]),
         .b              (req_b_i[g]),
         .control        (req_control_i[g]),
         .a_masked       (a_masked[g]),
         .b_masked       (b_masked[g]),
         .control_masked (control_masked[g])
      );
   end

   always_comb begin
      alu_a_o       = '0;
      alu_b_o       = '0;
      alu_control_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         alu_a_o       = alu_a_o | a_masked[i];
         alu_b_o       = alu_b_o | b_masked[i];
         alu_control_o = alu_control_o | control_masked[i];
      end
   end

   // A drain and a new accept in the same cycle simply overwrite the slot.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_o       <= 1'b0;
         rsp_id_o          <= '0;
         rsp_result_o      <= '0;
         rsp_branch_cond_o <= 1'b0;
      end else if (accept) begin
         rsp_valid_o       <= 1'b1;
         rsp_id_o          <= grant_id;
         rsp_result_o      <= alu_result_i;
         rsp_branch_cond_o <= alu_branch_cond_i;
      end else if (rsp_ready_i) begin
         rsp_valid_o       <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed literal checks plus randomized traffic against a cycle model.
// Honors ALU_ARB_FIXED_PRIO_EN to select the expected arbitration policy.

module tb_alu_arbiter;
   localparam int N    = 3;
   localparam int ID_W = $clog2(N);

   localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_AND = 4'd2, C_OR  = 4'd3,
                          C_XOR = 4'd4, C_SLL = 4'd5, C_SRL = 4'd6, C_LT  = 4'd7,
                          C_LTU = 4'd8, C_EQ  = 4'd9;

   logic                clk_i;
   logic                rst_i;
   logic [N-1:0]        req_valid_i;
   logic [N-1:0]        req_ready_o;
   logic [N-1:0][31:0]  req_a_i;
   logic [N-1:0][31:0]  req_b_i;
   logic [N-1:0][3:0]   req_control_i;
   logic [31:0]         alu_a_o;
   logic [31:0]         alu_b_o;
   logic [3:0]          alu_control_o;
   logic [31:0]         alu_result_i;
   logic                alu_branch_cond_i;
   logic                rsp_valid_o;
   logic                rsp_ready_i;
   logic [ID_W-1:0]     rsp_id_o;
   logic [31:0]         rsp_result_o;
   logic                rsp_branch_cond_o;

   alu_arbiter #(.NUM_REQ(N)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_a_i           (req_a_i),
      .req_b_i           (req_b_i),
      .req_control_i     (req_control_i),
      .alu_a_o           (alu_a_o),
      .alu_b_o           (alu_b_o),
      .alu_control_o     (alu_control_o),
      .alu_result_i      (alu_result_i),
      .alu_branch_cond_i (alu_branch_cond_i),
      .rsp_valid_o       (rsp_valid_o),
      .rsp_ready_i       (rsp_ready_i),
      .rsp_id_o          (rsp_id_o),
      .rsp_result_o      (rsp_result_o),
      .rsp_branch_cond_o (rsp_branch_cond_o)
   );

   // Stand-in for the shared ALU: {branch_cond, result}.
   function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
      logic [31:0] r;
      logic        bc;
      r  = '0;
      bc = 1'b0;
      case (c)
         C_ADD: r = a + b;
         C_SUB: r = a - b;
         C_AND: r = a & b;
         C_OR:  r = a | b;
         C_XOR: r = a ^ b;
         C_SLL: r = a << b[4:0];
         C_SRL: r = a >> b[4:0];
         C_LT:  begin r = {31'b0, $signed(a) < $signed(b)}; bc = r[0]; end
         C_LTU: begin r = {31'b0, a < b}; bc = r[0]; end
         C_EQ:  begin r = {31'b0, a == b}; bc = r[0]; end
         default: r = '0;
      endcase
      return {bc, r};
   endfunction

   assign {alu_branch_cond_i, alu_result_i} = alu_ref(alu_a_o, alu_b_o, alu_control_o);

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   // Cycle model: slot contents plus the index the next search starts from.
   logic            m_known = 1'b0;
   logic            m_valid;
   logic [ID_W-1:0] m_id;
   logic [31:0]     m_res;
   logic            m_bc;
   int              m_ptr;

   always @(negedge clk_i) begin
      int          g;
      int          best;
      int          d;
      logic        acc;
      logic [N-1:0] er;
      logic [32:0] ar;
      g    = -1;
      best = N;
      for (int i = 0; i < N; i++) begin
         if (req_valid_i[i]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            d = i;
`else
            d = (i - m_ptr + N) % N;
`endif
            if (d < best) begin
               best = d;
               g    = i;
            end
         end
      end
      acc = !rst_i && m_known && (g >= 0) && (!m_valid || rsp_ready_i);
      er  = '0;
      if (acc) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready_o), 32'(er));
      chk("alu_a",   alu_a_o,              acc ? req_a_i[g] : 32'd0);
      chk("alu_b",   alu_b_o,              acc ? req_b_i[g] : 32'd0);
      chk("alu_ctl", 32'(alu_control_o),   acc ? 32'(req_control_i[g]) : 32'd0);
      if (m_known) begin
         chk("rsp_valid",  32'(rsp_valid_o),       32'(m_valid));
         chk("rsp_id",     32'(rsp_id_o),          32'(m_id));
         chk("rsp_result", rsp_result_o,           m_res);
         chk("rsp_bc",     32'(rsp_branch_cond_o), 32'(m_bc));
      end
      if (rst_i) begin
         m_known = 1'b1;
         m_valid = 1'b0;
         m_id    = '0;
         m_res   = '0;
         m_bc    = 1'b0;
         m_ptr   = 0;
      end else if (acc) begin
         ar      = alu_ref(req_a_i[g], req_b_i[g], req_control_i[g]);
         m_valid = 1'b1;
         m_id    = ID_W'(g);
         m_res   = ar[31:0];
         m_bc    = ar[32];
         m_ptr   = (g + 1) % N;
      end else if (rsp_ready_i) begin
         m_valid = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic reset_dut();
      step();
      rst_i       = 1'b1;
      req_valid_i = '0;
      step();
      rst_i       = 1'b0;
   endtask

   logic [N-1:0] exp_rdy [4];
   logic [N-1:0] lr;

   initial begin
      rst_i         = 1'b1;
      rsp_ready_i   = 1'b1;
      req_valid_i   = '1;
      for (int i = 0; i < N; i++) begin
         req_a_i[i]       = 32'd5;
         req_b_i[i]       = 32'd3;
         req_control_i[i] = C_ADD;
      end

      // Reset holds every ready low; first grant after release goes to req0.
      repeat (2) begin
         @(negedge clk_i);
         chk("rst_ready", 32'(req_ready_o), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      end
      step();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("first_grant", 32'(req_ready_o), 32'b001);
      @(negedge clk_i);
      chk("add_valid", 32'(rsp_valid_o), 32'd1);
      chk("add_id", 32'(rsp_id_o), 32'd0);
      chk("add_result", rsp_result_o, 32'd8);

      // Two contenders: alternate under round-robin, req0 always under fixed priority.
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_rdy = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
      exp_rdy = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
      reset_dut();
      req_valid_i      = 3'b011;
      req_a_i[0]       = 32'd10; req_b_i[0] = 32'd1; req_control_i[0] = C_SUB;
      req_a_i[1]       = 32'd7;  req_b_i[1] = 32'd7; req_control_i[1] = C_EQ;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         chk("pair_ready", 32'(req_ready_o), 32'(exp_rdy[c]));
         if (c > 0) begin
            chk("pair_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("pair_rsp_id", 32'(rsp_id_o), exp_rdy[c-1][1] ? 32'd1 : 32'd0);
         end
         step();
      end

      // Backpressure: slot full and held, then drain and accept together.
      reset_dut();
      rsp_ready_i = 1'b0;
      req_valid_i = 3'b001;
      req_a_i[0] = 32'd1; req_b_i[0] = 32'd2; req_control_i[0] = C_ADD;
      @(negedge clk_i);
      chk("bp_first", 32'(req_ready_o), 32'b001);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk_i);
         chk("bp_ready", 32'(req_ready_o), 32'd0);
         chk("bp_valid", 32'(rsp_valid_o), 32'd1);
         chk("bp_result", rsp_result_o, 32'd3);
      end
      step();
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      chk("bp_drain_grant", 32'(req_ready_o), 32'b001);
      step();
      req_valid_i = '0;
      @(negedge clk_i);
      chk("bp_stay_valid", 32'(rsp_valid_o), 32'd1);

      // Signed vs unsigned compare on the same operands from req1.
      reset_dut();
      rsp_ready_i = 1'b1;
      req_valid_i = 3'b010;
      req_a_i[1] = 32'hFFFF_FFFF; req_b_i[1] = 32'd1; req_control_i[1] = C_LT;
      @(negedge clk_i);
      chk("lt_grant", 32'(req_ready_o), 32'b010);
      step();
      req_control_i[1] = C_LTU;
      @(negedge clk_i);
      chk("lt_result", rsp_result_o, 32'd1);
      chk("lt_bc", 32'(rsp_branch_cond_o), 32'd1);
      chk("lt_id", 32'(rsp_id_o), 32'd1);
      step();
      req_valid_i = '0;
      @(negedge clk_i);
      chk("ltu_result", rsp_result_o, 32'd0);
      chk("ltu_bc", 32'(rsp_branch_cond_o), 32'd0);
      chk("ltu_id", 32'(rsp_id_o), 32'd1);

      // Random traffic: stalled requests hold their operands or drop out.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_i);
         lr = req_ready_o;
         step();
         rst_i       = ($urandom_range(0, 60) == 0);
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (req_valid_i[i] && !lr[i]) begin
               if ($urandom_range(0, 7) == 0) req_valid_i[i] = 1'b0;
            end else begin
               req_valid_i[i]   = $urandom_range(0, 1) == 1;
               req_a_i[i]       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
               req_b_i[i]       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
               req_control_i[i] = 4'($urandom_range(0, 10));
            end
         end
      end
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
